// File: rtl/syncgen_pkg.sv
// Shared types, default VGA timing and config validation for syncgen_prog.
package syncgen_pkg;

  // Storage width of every timing field; CW of the generator must not exceed FW-2.
  localparam int FW = 16;

  typedef struct packed {
    logic [FW-1:0] hfp;
    logic [FW-1:0] hpw;
    logic [FW-1:0] hbp;
    logic [FW-1:0] hact;
    logic [FW-1:0] vfp;
    logic [FW-1:0] vpw;
    logic [FW-1:0] vbp;
    logic [FW-1:0] vact;
    logic          hpol;
    logic          vpol;
  } timing_cfg_t;

  // 640x480@60 defaults, both syncs active-low.
  localparam int   VGA_HFP  = 16;
  localparam int   VGA_HPW  = 96;
  localparam int   VGA_HBP  = 48;
  localparam int   VGA_HACT = 640;
  localparam int   VGA_VFP  = 10;
  localparam int   VGA_VPW  = 2;
  localparam int   VGA_VBP  = 33;
  localparam int   VGA_VACT = 480;
  localparam logic VGA_HPOL = 1'b0;
  localparam logic VGA_VPOL = 1'b0;

  // A config is usable when both pulses and both active regions are non-empty,
  // each axis total fits the CW-bit counter, and the horizontal blanking is long
  // enough to host the pre-DE lead. Field values are below 2^cw, so the wide
  // sums here equal the CW+2 bit sums of the datapath.
  function automatic logic cfg_valid(timing_cfg_t c, int unsigned cw, int unsigned pre_lead);
    logic [31:0] hstart;
    logic [31:0] htot;
    logic [31:0] vtot;
    logic [31:0] lim;
    hstart = 32'(c.hfp) + 32'(c.hpw) + 32'(c.hbp);
    htot   = hstart + 32'(c.hact);
    vtot   = 32'(c.vfp) + 32'(c.vpw) + 32'(c.vbp) + 32'(c.vact);
    lim    = 32'd1 << cw;
    return (c.hpw != '0) && (c.hact != '0) && (c.vpw != '0) && (c.vact != '0) &&
           (htot <= lim) && (vtot <= lim) && (pre_lead <= hstart);
  endfunction

endpackage

// File: rtl/syncgen_prog_cfg.sv
// Shadow/active timing registers: validates loads, tracks pending/error and
// swaps shadow into active when the top signals a frame boundary.
module syncgen_cfg
  import syncgen_pkg::*;
#(
  parameter int          CW       = 12,
  parameter int          PRE_LEAD = 1,
  parameter timing_cfg_t DEF_CFG  = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  timing_cfg_t cfg_i,
  input  logic        commit_req_i,
  output timing_cfg_t active_o,
  output timing_cfg_t shadow_o,
  output logic        pend_o,
  output logic        err_o,
  output logic        commit_o
);

  timing_cfg_t shadow_q, shadow_d;
  timing_cfg_t active_q, active_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic        load_ok;
  logic        commit;

  // Next-state: the old shadow commits even if a new load lands in the same cycle.
  always_comb begin
    load_ok  = load_i && cfg_valid(cfg_i, CW, PRE_LEAD);
    commit   = commit_req_i && pend_q;
    active_d = commit ? shadow_q : active_q;
    shadow_d = load_ok ? cfg_i : shadow_q;
    pend_d   = load_ok ? 1'b1 : (commit ? 1'b0 : pend_q);
    err_d    = load_i ? !load_ok : err_q;
  end

  // Register update; reset restores defaults and drops any pending config.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= DEF_CFG;
      active_q <= DEF_CFG;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign active_o = active_q;
  assign shadow_o = shadow_q;
  assign pend_o   = pend_q;
  assign err_o    = err_q;
  assign commit_o = commit;

endmodule

// File: rtl/syncgen_prog.sv
// Programmable sync generator: IDLE/RUN control, pixel/line counters and
// registered sync / pre-DE / frame-start decode.
module syncgen_prog
  import syncgen_pkg::*;
#(
  parameter int CW       = 12,
  parameter int PRE_LEAD = 1,
  parameter int DEF_HFP  = VGA_HFP,
  parameter int DEF_HPW  = VGA_HPW,
  parameter int DEF_HBP  = VGA_HBP,
  parameter int DEF_HACT = VGA_HACT,
  parameter int DEF_VFP  = VGA_VFP,
  parameter int DEF_VPW  = VGA_VPW,
  parameter int DEF_VBP  = VGA_VBP,
  parameter int DEF_VACT = VGA_VACT
) (
  input  logic          DCLK,
  input  logic          DRST,
  input  logic          ENABLE,
  input  logic [CW-1:0] CFG_HFP,
  input  logic [CW-1:0] CFG_HPW,
  input  logic [CW-1:0] CFG_HBP,
  input  logic [CW-1:0] CFG_HACT,
  input  logic [CW-1:0] CFG_VFP,
  input  logic [CW-1:0] CFG_VPW,
  input  logic [CW-1:0] CFG_VBP,
  input  logic [CW-1:0] CFG_VACT,
  input  logic          CFG_HPOL,
  input  logic          CFG_VPOL,
  input  logic          CFG_LOAD,
  output logic          CFG_PEND,
  output logic          CFG_ERR,
  output logic          DSP_HSYNC,
  output logic          DSP_VSYNC,
  output logic          DSP_preDE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          FRAME_START,
  output logic [0:0]    DBG_STATE
);

  localparam int SW = CW + 2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam timing_cfg_t DEF_CFG = '{
    hfp: FW'(DEF_HFP), hpw: FW'(DEF_HPW), hbp: FW'(DEF_HBP), hact: FW'(DEF_HACT),
    vfp: FW'(DEF_VFP), vpw: FW'(DEF_VPW), vbp: FW'(DEF_VBP), vact: FW'(DEF_VACT),
    hpol: VGA_HPOL, vpol: VGA_VPOL
  };

  function automatic logic [SW-1:0] fld(input logic [FW-1:0] f);
    return SW'(f);
  endfunction

  timing_cfg_t   cfg_in, act_q, shd_q, act_nxt;
  logic          commit, commit_req, pend, err;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, prede_q, prede_d, fs_q, fs_d;
  logic [SW-1:0] h_tot_cur, v_tot_cur;
  logic [SW-1:0] h_fp, h_sync_end, h_start, h_tot_n, v_fp, v_sync_end, v_start;
  logic [SW-1:0] hn, vn, hn_lead;
  logic          h_last, v_last, run_n, hs_on, vs_on;

  // CFG_LOAD is a single-cycle request with no ready: every asserted cycle is a
  // capture attempt, answered next cycle by CFG_PEND (accepted) or CFG_ERR (rejected).
  always_comb begin
    cfg_in = '{
      hfp: FW'(CFG_HFP), hpw: FW'(CFG_HPW), hbp: FW'(CFG_HBP), hact: FW'(CFG_HACT),
      vfp: FW'(CFG_VFP), vpw: FW'(CFG_VPW), vbp: FW'(CFG_VBP), vact: FW'(CFG_VACT),
      hpol: CFG_HPOL, vpol: CFG_VPOL
    };
  end

  syncgen_cfg #(
    .CW       (CW),
    .PRE_LEAD (PRE_LEAD),
    .DEF_CFG  (DEF_CFG)
  ) u_cfg (
    .clk_i        (DCLK),
    .rst_i        (DRST),
    .load_i       (CFG_LOAD),
    .cfg_i        (cfg_in),
    .commit_req_i (commit_req),
    .active_o     (act_q),
    .shadow_o     (shd_q),
    .pend_o       (pend),
    .err_o        (err),
    .commit_o     (commit)
  );

  // Counter advance and commit request, using the timing of the current frame.
  always_comb begin
    h_tot_cur  = fld(act_q.hfp) + fld(act_q.hpw) + fld(act_q.hbp) + fld(act_q.hact);
    v_tot_cur  = fld(act_q.vfp) + fld(act_q.vpw) + fld(act_q.vbp) + fld(act_q.vact);
    h_last     = ({2'b00, hcnt_q} + SW'(1)) == h_tot_cur;
    v_last     = ({2'b00, vcnt_q} + SW'(1)) == v_tot_cur;
    // Idle counts as a permanent frame boundary so a pending config lands at once.
    commit_req = (state_q == ST_IDLE) || (h_last && v_last);
    state_d    = ENABLE ? ST_RUN : ST_IDLE;
    hcnt_d     = '0;
    vcnt_d     = '0;
    if (ENABLE && (state_q == ST_RUN)) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
      end
    end
  end

  // Output decode from next-cycle position and next-cycle timing, so the
  // registered outputs stay mutually consistent across a commit.
  always_comb begin
    act_nxt    = commit ? shd_q : act_q;
    h_fp       = fld(act_nxt.hfp);
    h_sync_end = h_fp + fld(act_nxt.hpw);
    h_start    = h_sync_end + fld(act_nxt.hbp);
    h_tot_n    = h_start + fld(act_nxt.hact);
    v_fp       = fld(act_nxt.vfp);
    v_sync_end = v_fp + fld(act_nxt.vpw);
    v_start    = v_sync_end + fld(act_nxt.vbp);
    hn         = {2'b00, hcnt_d};
    vn         = {2'b00, vcnt_d};
    hn_lead    = hn + SW'(PRE_LEAD);
    run_n      = (state_d == ST_RUN);
    hs_on      = run_n && (hn >= h_fp) && (hn < h_sync_end);
    vs_on      = run_n && (vn >= v_fp) && (vn < v_sync_end);
    hsync_d    = hs_on ? act_nxt.hpol : ~act_nxt.hpol;
    vsync_d    = vs_on ? act_nxt.vpol : ~act_nxt.vpol;
    prede_d    = run_n && (vn >= v_start) && (hn_lead >= h_start) && (hn_lead < h_tot_n);
    fs_d       = run_n && (hcnt_d == '0) && (vcnt_d == '0);
  end

  // State, counters and output registers.
  always_ff @(posedge DCLK or posedge DRST) begin
    if (DRST) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= ~DEF_CFG.hpol;
      vsync_q <= ~DEF_CFG.vpol;
      prede_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      prede_q <= prede_d;
      fs_q    <= fs_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign DSP_HSYNC   = hsync_q;
  assign DSP_VSYNC   = vsync_q;
  assign DSP_preDE   = prede_q;
  assign FRAME_START = fs_q;
  assign CFG_PEND    = pend;
  assign CFG_ERR     = err;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_syncgen_prog.sv
// Bench for syncgen_prog: random and directed stimulus against a frame-position model.
module tb_syncgen_prog;

  localparam int CW       = 12;
  localparam int PRE_LEAD = 1;

  typedef struct {
    int hfp, hpw, hbp, hact, vfp, vpw, vbp, vact;
    bit hpol, vpol;
  } tcfg_t;

  localparam tcfg_t DEF_T = '{hfp: 16, hpw: 96, hbp: 48, hact: 640,
                              vfp: 10, vpw: 2, vbp: 33, vact: 480, hpol: 0, vpol: 0};

  // ---------------- clock / reset / DUT ----------------
  logic          dclk = 1'b0;
  logic          drst, enable, cfg_load;
  tcfg_t         drv_cfg;
  logic [CW-1:0] cfg_hfp, cfg_hpw, cfg_hbp, cfg_hact, cfg_vfp, cfg_vpw, cfg_vbp, cfg_vact;
  logic          cfg_hpol, cfg_vpol;
  logic          cfg_pend, cfg_err, hsync, vsync, prede, frame_start;
  logic [CW-1:0] hcnt, vcnt;
  logic [0:0]    dbg_state;

  always #5 dclk = ~dclk;

  assign cfg_hfp  = CW'(drv_cfg.hfp);
  assign cfg_hpw  = CW'(drv_cfg.hpw);
  assign cfg_hbp  = CW'(drv_cfg.hbp);
  assign cfg_hact = CW'(drv_cfg.hact);
  assign cfg_vfp  = CW'(drv_cfg.vfp);
  assign cfg_vpw  = CW'(drv_cfg.vpw);
  assign cfg_vbp  = CW'(drv_cfg.vbp);
  assign cfg_vact = CW'(drv_cfg.vact);
  assign cfg_hpol = drv_cfg.hpol;
  assign cfg_vpol = drv_cfg.vpol;

  syncgen_prog #(.CW(CW), .PRE_LEAD(PRE_LEAD)) dut (
    .DCLK(dclk), .DRST(drst), .ENABLE(enable),
    .CFG_HFP(cfg_hfp), .CFG_HPW(cfg_hpw), .CFG_HBP(cfg_hbp), .CFG_HACT(cfg_hact),
    .CFG_VFP(cfg_vfp), .CFG_VPW(cfg_vpw), .CFG_VBP(cfg_vbp), .CFG_VACT(cfg_vact),
    .CFG_HPOL(cfg_hpol), .CFG_VPOL(cfg_vpol), .CFG_LOAD(cfg_load),
    .CFG_PEND(cfg_pend), .CFG_ERR(cfg_err),
    .DSP_HSYNC(hsync), .DSP_VSYNC(vsync), .DSP_preDE(prede),
    .HCNT(hcnt), .VCNT(vcnt), .FRAME_START(frame_start), .DBG_STATE(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      fail_cnt++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, expv);
      if (fail_cnt >= 50) finish_run();
    end
  endtask

  // ---------------- reference model ----------------
  // Position is the cycle index within the current frame; HCNT/VCNT follow by division.
  bit    m_run, m_pend, m_err;
  int    m_pos;
  tcfg_t m_act, m_shd;

  function automatic int htot(tcfg_t c); return c.hfp + c.hpw + c.hbp + c.hact; endfunction
  function automatic int vtot(tcfg_t c); return c.vfp + c.vpw + c.vbp + c.vact; endfunction

  function automatic bit model_ok(tcfg_t c);
    return c.hpw != 0 && c.hact != 0 && c.vpw != 0 && c.vact != 0 &&
           htot(c) <= (1 << CW) && vtot(c) <= (1 << CW) &&
           PRE_LEAD <= c.hfp + c.hpw + c.hbp;
  endfunction

  function automatic bit model_at_last();
    return m_run && (m_pos == htot(m_act) * vtot(m_act) - 1);
  endfunction

  function automatic int model_h();
    return m_run ? m_pos % htot(m_act) : 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_act = DEF_T; m_shd = DEF_T; m_pend = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int frame;
    bit commit, ok;
    frame  = htot(m_act) * vtot(m_act);
    commit = m_pend && (!m_run || m_pos == frame - 1);
    ok     = cfg_load && model_ok(drv_cfg);
    if (!enable)     begin m_run = 0; m_pos = 0; end
    else if (!m_run) begin m_run = 1; m_pos = 0; end
    else m_pos = (m_pos + 1) % frame;
    if (commit) m_act = m_shd;
    if (ok) begin
      m_shd = drv_cfg; m_pend = 1; m_err = 0;
    end else begin
      if (commit)   m_pend = 0;
      if (cfg_load) m_err = 1;
    end
  endtask

  task automatic compare_all();
    int h, v, ht, hstart, vstart;
    bit hs_on, vs_on, de, fs, exp_hs, exp_vs;
    ht     = htot(m_act);
    h      = m_run ? m_pos % ht : 0;
    v      = m_run ? m_pos / ht : 0;
    hstart = m_act.hfp + m_act.hpw + m_act.hbp;
    vstart = m_act.vfp + m_act.vpw + m_act.vbp;
    hs_on  = m_run && h >= m_act.hfp && h < m_act.hfp + m_act.hpw;
    vs_on  = m_run && v >= m_act.vfp && v < m_act.vfp + m_act.vpw;
    exp_hs = hs_on ? m_act.hpol : !m_act.hpol;
    exp_vs = vs_on ? m_act.vpol : !m_act.vpol;
    de     = m_run && v >= vstart && h >= hstart - PRE_LEAD && h < ht - PRE_LEAD;
    fs     = m_run && m_pos == 0;
    check_eq("hcnt",  32'(hcnt),        32'(h));
    check_eq("vcnt",  32'(vcnt),        32'(v));
    check_eq("hsync", 32'(hsync),       32'(exp_hs));
    check_eq("vsync", 32'(vsync),       32'(exp_vs));
    check_eq("prede", 32'(prede),       32'(de));
    check_eq("fs",    32'(frame_start), 32'(fs));
    check_eq("pend",  32'(cfg_pend),    32'(m_pend));
    check_eq("err",   32'(cfg_err),     32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge dclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load_step(tcfg_t c);
    drv_cfg  = c;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  function automatic tcfg_t rand_cfg(bit allow_bad);
    tcfg_t c;
    c.hfp  = $urandom_range(0, 5);  c.hpw  = $urandom_range(1, 4);
    c.hbp  = $urandom_range(0, 5);  c.hact = $urandom_range(4, 12);
    c.vfp  = $urandom_range(0, 2);  c.vpw  = $urandom_range(1, 2);
    c.vbp  = $urandom_range(0, 2);  c.vact = $urandom_range(2, 4);
    c.hpol = 1'($urandom_range(0, 1));
    c.vpol = 1'($urandom_range(0, 1));
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 4))
        0: c.hpw = 0;
        1: c.hact = 0;
        2: c.vpw = 0;
        3: c.vact = 0;
        default: begin c.hbp = 5; c.hact = 4095; end
      endcase
    end
    return c;
  endfunction

  task automatic pulse_reset_mid();
    @(posedge dclk);
    model_edge();
    #1;
    compare_all();
    #1;
    drst = 1'b1;
    #1;
    model_reset();
    compare_all();
    drst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tcfg_t c;
    drv_cfg  = DEF_T;
    cfg_load = 1'b0;
    enable   = 1'b0;
    drst     = 1'b1;
    model_reset();
    repeat (2) @(posedge dclk);
    #1;
    compare_all();
    drst = 1'b0;
    step();

    // Default 640x480 timing through line 45, with rejects and loads mid-frame.
    enable = 1'b1;
    for (int i = 0; i < 46 * 800 + 10; i++) begin
      cfg_load = 1'b0;
      if (i == 1000) begin c = DEF_T; c.hpw = 0;     drv_cfg = c; cfg_load = 1'b1; end
      if (i == 2000) begin c = DEF_T; c.hact = 4000; drv_cfg = c; cfg_load = 1'b1; end
      if (i == 2500) begin c = DEF_T; c.hact = 3936; drv_cfg = c; cfg_load = 1'b1; end
      if (i == 3000) begin
        drv_cfg = '{hfp: 110, hpw: 40, hbp: 220, hact: 1280,
                    vfp: 5, vpw: 5, vbp: 20, vact: 720, hpol: 1, vpol: 1};
        cfg_load = 1'b1;
      end
      step();
    end
    cfg_load = 1'b0;

    // Drop ENABLE at HCNT=300; idle commits the pending 1280x720 timing.
    for (int k = 0; k < 2000 && model_h() != 300; k++) step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    for (int k = 0; k < 2 * 1650 + 10; k++) step();

    // Install a small timing while idle, then two loads plus a commit-cycle load.
    enable = 1'b0;
    step();
    load_step(rand_cfg(0));
    step();
    enable = 1'b1;
    step();
    load_step(rand_cfg(0));
    step();
    step();
    load_step(rand_cfg(0));
    for (int k = 0; k < 2000 && !model_at_last(); k++) step();
    load_step(rand_cfg(0));
    for (int k = 0; k < 1500; k++) step();

    // Random loads (some invalid) and ENABLE gaps.
    for (int i = 0; i < 10000; i++) begin
      cfg_load = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        drv_cfg  = rand_cfg(1);
        cfg_load = 1'b1;
      end
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
      step();
    end
    cfg_load = 1'b0;

    // Asynchronous reset with a config pending, then defaults must be back.
    enable = 1'b1;
    step();
    load_step(rand_cfg(0));
    pulse_reset_mid();
    for (int k = 0; k < 900; k++) step();

    finish_run();
  end

  initial begin
    #3000000;
    fail_cnt++;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    finish_run();
  end

endmodule
